knn_dma_v1_0_m00_axi_mm2s_reg_wrap: RTL and testbench
=====================================================

# knn_dma_v1_0_m00_axi_mm2s_reg_wrap

AXI4 full read master (memory-map-to-stream) for the KNN DMA engine. On `start` it captures a byte address and byte length. It issues INCR read bursts of up to `C_M_AXI_BURST_LEN` beats without crossing 4 KB boundaries, and forwards every returned data beat to the KNN datapath as a `wr_en`/`data_out` write strobe. It sits between the AXI interconnect (HP/ACP port) and the KNN input FIFO, and reports `transfer_done` and `error` to the control registers.

## Interface
- C_M_AXI_BURST_LEN, 256, max beats per burst (1..256, power of 2)
- C_M_AXI_ID_WIDTH, 1, ARID/RID width
- C_M_AXI_ADDR_WIDTH, 32, address width
- C_M_AXI_DATA_WIDTH, 64, data width; bytes per beat B = width/8
- C_M_AXI_ARUSER_WIDTH, 0, ARUSER width; port is max(1,value) bits
- C_M_AXI_RUSER_WIDTH, 0, RUSER width; port is max(1,value) bits
- M_AXI_ACLK  in  1  single clock; all logic rising-edge
- M_AXI_ARESETN  in  1  asynchronous, active-high reset (high = reset, despite the name)
- start  in  1  level request; sampled in IDLE
- starting_addr  in  ADDR  byte start address; must be B-aligned
- starting_length  in  32  transfer length in bytes
- wr_en  out  1  one-cycle strobe per received beat
- data_out  out  DATA  beat data, valid when wr_en=1
- transfer_done  out  1  high in DONE state
- error  out  1  sticky error flag for the current transfer
- M_AXI_ARID  out  ID  constant 0
- M_AXI_ARADDR  out  ADDR  burst address
- M_AXI_ARLEN  out  8  beats-1
- M_AXI_ARSIZE  out  3  log2(B); 3'b011 for 64-bit
- M_AXI_ARBURST  out  2  constant 2'b01 (INCR)
- M_AXI_ARLOCK  out  1  constant 0
- M_AXI_ARCACHE  out  4  constant 4'b0011
- M_AXI_ARPROT  out  3  constant 0
- M_AXI_ARQOS  out  4  constant 0
- M_AXI_ARUSER  out  ARUSER  constant 0
- M_AXI_ARVALID  out  1  address valid
- M_AXI_ARREADY  in  1  address ready
- M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RUSER, M_AXI_RVALID  in  read data channel (RID/RUSER ignored)
- M_AXI_RREADY  out  1  data ready

## Operation
- Total beats N = ceil(starting_length / B). Registers: cur_addr, beats_left, burst_cnt, burst_len.
- IDLE: when start=1, latch addr, set N, clear error. If addr[log2B-1:0]≠0, set error and go to DONE. If N=0, go to DONE. Otherwise go to ADDR.
- ADDR: burst beats L = min(beats_left, C_M_AXI_BURST_LEN, (4096 − cur_addr[11:0])/B). Drive ARADDR=cur_addr, ARLEN=L−1, ARVALID=1. ARADDR and ARLEN stay stable until ARREADY. On ARVALID&ARREADY, go to DATA.
- DATA: RREADY=1, with no backpressure. On each RVALID&RREADY: wr_en/data_out, burst_cnt++. If RRESP[1]=1 (SLVERR/DECERR), set error. The burst ends on the beat with RLAST=1. If that beat is not beat L, set error. At burst end: cur_addr += L·B and beats_left −= L. If beats_left=0, go to DONE; otherwise go to ADDR.
- DONE: transfer_done=1. Return to IDLE when start=0. error holds until the next start.
- Only one burst is outstanding at a time.
- The final partial word (length not a multiple of B) is delivered as a full beat.
- Changes to starting_addr and starting_length after capture are ignored.

## Timing
- Reset (asynchronous, immediate): state IDLE. ARVALID, RREADY, wr_en, transfer_done and error = 0. data_out=0, ARADDR=0, ARLEN=0. The constant outputs hold their constants.
- Reset mid-burst aborts immediately. Outstanding R beats after reset release are not consumed, because RREADY=0 in IDLE.
- start high at edge k in IDLE: ARVALID=1 after edge k+1. L is computed registered in that cycle.
- ARVALID drops on the edge after the handshake. RREADY=1 from the next cycle until the RLAST handshake.
- Data latency: RVALID&RREADY at edge t gives wr_en=1 and data_out=RDATA during cycle t→t+1 (registered, 1 cycle). Back-to-back beats give back-to-back wr_en.
- A new ARVALID follows the RLAST handshake by 1 cycle (ADDR state, 1-cycle gap minimum).
- transfer_done rises 1 cycle after the last RLAST handshake, coincident with the final wr_en.

## Test plan
- Reset held 90 ns, ARREADY=1, addr=0x1238, len=0xFFFF, start=1 → bursts: 0x1238/ARLEN=255, 0x1A38/ARLEN=184, 0x2000/ARLEN=255, and so on; every burst ≤256 beats and stays within 4 KB; 8192 wr_en pulses in total; then transfer_done=1 and error=0.
- addr=0x0, len=16, ARREADY delayed 3 cycles → ARADDR/ARLEN=1 held stable through the wait; 2 wr_en pulses with data matching RDATA; done.
- len=0 → no ARVALID; transfer_done=1 within 2 cycles; error=0.
- addr=0x1004 (misaligned) → no ARVALID; transfer_done=1 and error=1; start low → IDLE; a new aligned start clears error.
- RRESP=2'b10 on beat 3, or RLAST early on beat 5 of 8 → error=1 sticky; transfer still completes and done=1.
- Reset asserted mid-DATA → ARVALID, RREADY and wr_en drop to 0 immediately; after release, IDLE and a fresh start works.

Source files
------------

// File: rtl/knn_dma_v1_0_m00_axi_mm2s_reg_wrap.sv
// Purpose: AXI4 read master that streams a byte range from memory into the KNN input write port.
// Latency: ARVALID 2 cycles after start; each R beat appears on wr_en/data_out 1 cycle after its handshake.
// Backpressure: none toward the datapath (RREADY held high for the whole burst); one burst outstanding at a time.
//
// Ports:
//   M_AXI_ACLK / M_AXI_ARESETN   clock / asynchronous active-high reset (high = reset)
//   start, starting_addr,        transfer request (level), byte address (beat aligned),
//   starting_length              byte length; all captured once in IDLE
//   wr_en, data_out              one strobe per received beat toward the KNN FIFO
//   transfer_done, error         status: done level in DONE, sticky error per transfer
//   M_AXI_AR*, M_AXI_R*          AXI4 read address / read data channels
`timescale 1ns/1ps
module knn_dma_v1_0_m00_axi_mm2s_reg_wrap #(
  parameter int C_M_AXI_BURST_LEN    = 256,
  parameter int C_M_AXI_ID_WIDTH     = 1,
  parameter int C_M_AXI_ADDR_WIDTH   = 32,
  parameter int C_M_AXI_DATA_WIDTH   = 64,
  parameter int C_M_AXI_ARUSER_WIDTH = 0,
  parameter int C_M_AXI_RUSER_WIDTH  = 0
) (
  input  logic                                      M_AXI_ACLK,
  input  logic                                      M_AXI_ARESETN,
  input  logic                                      start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]             starting_addr,
  input  logic [31:0]                               starting_length,
  output logic                                      wr_en,
  output logic [C_M_AXI_DATA_WIDTH-1:0]             data_out,
  output logic                                      transfer_done,
  output logic                                      error,
  output logic [C_M_AXI_ID_WIDTH-1:0]               M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]             M_AXI_ARADDR,
  output logic [7:0]                                M_AXI_ARLEN,
  output logic [2:0]                                M_AXI_ARSIZE,
  output logic [1:0]                                M_AXI_ARBURST,
  output logic                                      M_AXI_ARLOCK,
  output logic [3:0]                                M_AXI_ARCACHE,
  output logic [2:0]                                M_AXI_ARPROT,
  output logic [3:0]                                M_AXI_ARQOS,
  output logic [(C_M_AXI_ARUSER_WIDTH > 0 ? C_M_AXI_ARUSER_WIDTH : 1)-1:0] M_AXI_ARUSER,
  output logic                                      M_AXI_ARVALID,
  input  logic                                      M_AXI_ARREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]               M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]             M_AXI_RDATA,
  input  logic [1:0]                                M_AXI_RRESP,
  input  logic                                      M_AXI_RLAST,
  input  logic [(C_M_AXI_RUSER_WIDTH > 0 ? C_M_AXI_RUSER_WIDTH : 1)-1:0] M_AXI_RUSER,
  input  logic                                      M_AXI_RVALID,
  output logic                                      M_AXI_RREADY
);

  localparam int BYTES = C_M_AXI_DATA_WIDTH / 8;
  localparam int LOG2B = $clog2(BYTES);
  localparam int AW    = C_M_AXI_ADDR_WIDTH;

  // S_CALC is the registered burst-length cycle that sits in front of every
  // address phase; it gives the one-cycle gap before each ARVALID.
  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic          clk;
  logic          rst;
  assign clk = M_AXI_ACLK;
  assign rst = M_AXI_ARESETN;

  logic [AW-1:0] cur_addr;
  logic [31:0]   beats_left;
  logic [8:0]    burst_len;
  logic [8:0]    burst_cnt;
  logic [8:0]    beat_num;
  logic [7:0]    arlen_q;

  // RID, RUSER and the low RRESP bit carry nothing this master acts on.
  logic unused_inputs;
  assign unused_inputs = ^{M_AXI_RID, M_AXI_RUSER, M_AXI_RRESP[0]};

  // Request capture: beat count rounds the byte length up to whole beats.
  logic [32:0] len_round;
  logic [31:0] start_beats;
  logic        misaligned;
  assign len_round   = {1'b0, starting_length} + 33'(BYTES - 1);
  assign start_beats = 32'(len_round >> LOG2B);
  assign misaligned  = (starting_addr & AW'(BYTES - 1)) != '0;

  // Burst length: remaining beats, clipped to the max burst and to the
  // beats left before the next 4 KB page boundary.
  logic [12:0] page_bytes;
  logic [31:0] page_beats;
  logic [31:0] burst_calc;
  assign page_bytes = 13'd4096 - {1'b0, cur_addr[11:0]};
  assign page_beats = 32'(page_bytes >> LOG2B);

  always_comb begin
    burst_calc = beats_left;
    if (burst_calc > 32'(C_M_AXI_BURST_LEN)) burst_calc = 32'(C_M_AXI_BURST_LEN);
    if (burst_calc > page_beats)             burst_calc = page_beats;
  end

  logic r_hs;
  assign r_hs     = (state_q == S_DATA) && M_AXI_RVALID;
  assign beat_num = burst_cnt + 9'd1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = (misaligned || start_beats == 32'd0) ? S_DONE : S_CALC;
      S_CALC: state_d = S_ADDR;
      S_ADDR: if (M_AXI_ARREADY) state_d = S_DATA;
      S_DATA: if (r_hs && M_AXI_RLAST)
                state_d = (beats_left == 32'(burst_len)) ? S_DONE : S_CALC;
      S_DONE: if (!start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr   <= '0;
      beats_left <= '0;
      burst_len  <= '0;
      burst_cnt  <= '0;
      arlen_q    <= '0;
      wr_en      <= 1'b0;
      data_out   <= '0;
      error      <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cur_addr   <= starting_addr;
            beats_left <= start_beats;
            error      <= misaligned;
          end
        end
        S_CALC: begin
          burst_len <= 9'(burst_calc);
          arlen_q   <= 8'(burst_calc - 32'd1);
          burst_cnt <= '0;
        end
        S_DATA: begin
          if (r_hs) begin
            wr_en     <= 1'b1;
            data_out  <= M_AXI_RDATA;
            burst_cnt <= beat_num;
            if (M_AXI_RRESP[1]) error <= 1'b1;
            // Flag RLAST on the wrong beat, or a burst running past L without RLAST.
            if (M_AXI_RLAST ? (beat_num != burst_len) : (beat_num >= burst_len)) error <= 1'b1;
            // The transfer advances by the requested length even if RLAST came
            // early, so a misbehaving slave cannot stall the engine.
            if (M_AXI_RLAST) begin
              cur_addr   <= cur_addr + (AW'(burst_len) << LOG2B);
              beats_left <= beats_left - 32'(burst_len);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign M_AXI_ARVALID = (state_q == S_ADDR);
  assign M_AXI_RREADY  = (state_q == S_DATA);
  assign transfer_done = (state_q == S_DONE);
  assign M_AXI_ARADDR  = cur_addr;
  assign M_AXI_ARLEN   = arlen_q;

  assign M_AXI_ARID    = '0;
  assign M_AXI_ARSIZE  = 3'(LOG2B);
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = 4'b0011;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARQOS   = 4'b0000;
  assign M_AXI_ARUSER  = '0;

endmodule

// File: tb/tb_knn_dma_v1_0_m00_axi_mm2s_reg_wrap.sv
`timescale 1ns/1ps
module tb_knn_dma_v1_0_m00_axi_mm2s_reg_wrap;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [31:0] starting_addr = '0;
  logic [31:0] starting_length = '0;
  logic        wr_en;
  logic [63:0] data_out;
  logic        transfer_done;
  logic        error;
  logic [0:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic [3:0]  arqos;
  logic [0:0]  aruser;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [0:0]  rid = '0;
  logic [63:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic [0:0]  ruser = '0;
  logic        rvalid = 1'b0;
  logic        rready;

  knn_dma_v1_0_m00_axi_mm2s_reg_wrap dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst),
    .start(start), .starting_addr(starting_addr), .starting_length(starting_length),
    .wr_en(wr_en), .data_out(data_out), .transfer_done(transfer_done), .error(error),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
    .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache),
    .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos), .M_AXI_ARUSER(aruser),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
    .M_AXI_RUSER(ruser), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  int total = 0;
  int bad   = 0;
  int cur_vec = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL vec%0d %s: actual=%0h required=%0h", cur_vec, name, act, exp);
    end
  endtask

  // ---------------- AXI slave + scoreboard (drives on negedge) ----------------
  int          ar_delay = 0;
  int          err_beat = -1;
  int          early_last = -1;
  int          ar_wait = 0;
  bit          r_active = 1'b0;
  int          r_beats = 0;
  int          beat_idx = 0;
  int          burst_no = 0;
  logic        prev_arvalid = 1'b0;
  logic        prev_rready = 1'b0;
  logic [31:0] prev_araddr = '0;
  logic [7:0]  prev_arlen = '0;
  logic [31:0] first_araddr = '0;
  logic [7:0]  first_arlen = '0;
  logic [63:0] exp_q[$];
  int          n_bursts = 0;
  int          n_beats = 0;
  logic [31:0] m_addr = '0;
  int          m_left = 0;
  int          m_l = 0;
  int          m_pg = 0;
  logic [31:0] log_addr[$];
  int          log_len[$];

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        r_active = 1'b0; ar_wait = 0;
        prev_arvalid = 1'b0; prev_rready = 1'b0;
        exp_q.delete();
      end else begin
        if (prev_arvalid && arready) begin
          // Expected burst: min(remaining, 256, beats to 4 KB page end)
          m_l  = m_left;
          m_pg = (4096 - int'(m_addr[11:0])) / 8;
          if (m_l > 256)  m_l = 256;
          if (m_l > m_pg) m_l = m_pg;
          chk("ar_addr", 64'(prev_araddr), 64'(m_addr));
          chk("ar_len", 64'(prev_arlen), 64'(m_l - 1));
          chk("ar_addr_stable", 64'(first_araddr), 64'(prev_araddr));
          chk("ar_len_stable", 64'(first_arlen), 64'(prev_arlen));
          chk("ar_in_4k", 64'((int'(prev_araddr[11:0]) + (int'(prev_arlen) + 1) * 8) <= 4096), 64'd1);
          log_addr.push_back(prev_araddr);
          log_len.push_back(int'(prev_arlen));
          n_bursts++;
          m_addr = m_addr + 32'(m_l * 8);
          m_left = m_left - m_l;
          r_active = 1'b1; r_beats = int'(prev_arlen) + 1; beat_idx = 0;
          burst_no++; arready = 1'b0; ar_wait = 0;
        end
        if (prev_rready && rvalid) begin
          exp_q.push_back(rdata);
          beat_idx++;
          if (rlast) r_active = 1'b0;
        end
        if (wr_en) begin
          n_beats++;
          if (exp_q.size() == 0) chk("wr_unexpected", 64'd1, 64'd0);
          else                   chk("wr_data", data_out, exp_q.pop_front());
        end
        if (arvalid && !arready) begin
          if (!prev_arvalid) begin
            first_araddr = araddr;
            first_arlen  = arlen;
          end
          if (ar_wait >= ar_delay) arready = 1'b1;
          else ar_wait++;
        end
        if (r_active) begin
          rvalid = 1'b1;
          rdata  = {16'hA5C3, 16'(burst_no), 32'(beat_idx)};
          rlast  = (beat_idx == r_beats - 1) || (beat_idx == early_last);
          rresp  = (beat_idx == err_beat) ? 2'b10 : 2'b00;
        end else begin
          rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        end
        prev_arvalid = arvalid;
        prev_rready  = rready;
        prev_araddr  = araddr;
        prev_arlen   = arlen;
      end
    end
  end

  // ---------------- Vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] len;
    int          ar_delay;
    int          err_beat;
    int          early_last;
    int          exp_bursts;
    int          exp_beats;
    logic        exp_error;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];

  task automatic run_vec(input vec_t v);
    int cyc;
    ar_delay = v.ar_delay; err_beat = v.err_beat; early_last = v.early_last;
    m_addr = v.addr; m_left = int'((v.len + 32'd7) / 32'd8);
    n_bursts = 0; n_beats = 0;
    log_addr.delete(); log_len.delete();
    starting_addr = v.addr; starting_length = v.len; start = 1'b1;
    @(negedge clk);
    // Inputs after capture must have no effect.
    starting_addr = 32'hDEAD_BEE8; starting_length = 32'h40;
    chk("arvalid_after_k", 64'(arvalid), 64'd0);
    chk("error_at_start", 64'(error), 64'(v.addr[2:0] != 3'd0));
    if (v.exp_bursts > 0) begin
      @(negedge clk);
      chk("arvalid_after_k1", 64'(arvalid), 64'd1);
    end
    cyc = 0;
    while (!transfer_done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    #1;
    chk("done", 64'(transfer_done), 64'd1);
    if (v.exp_bursts == 0) chk("done_immediate", 64'(cyc), 64'd0);
    else                   chk("done_with_last_wr", 64'(wr_en), 64'd1);
    chk("bursts", 64'(n_bursts), 64'(v.exp_bursts));
    chk("beats", 64'(n_beats), 64'(v.exp_beats));
    chk("error", 64'(error), 64'(v.exp_error));
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("done_clears", 64'(transfer_done), 64'd0);
    chk("error_held", 64'(error), 64'(v.exp_error));
    chk("idle_no_arvalid", 64'(arvalid), 64'd0);
  endtask

  initial begin
    int cyc;
    //          addr          len           dly err  early bursts beats err
    vecs[0] = '{32'h0000_1238, 32'h0000_FFFF, 0, -1, -1,   33,    8192, 1'b0};
    vecs[1] = '{32'h0000_0000, 32'd16,        3, -1, -1,    1,       2, 1'b0};
    vecs[2] = '{32'h0000_0100, 32'd0,         0, -1, -1,    0,       0, 1'b0};
    vecs[3] = '{32'h0000_1004, 32'd64,        0, -1, -1,    0,       0, 1'b1};
    vecs[4] = '{32'h0000_2000, 32'd64,        0,  2, -1,    1,       8, 1'b1};
    vecs[5] = '{32'h0000_3000, 32'd64,        0, -1,  4,    1,       5, 1'b1};
    vecs[6] = '{32'h0000_0040, 32'd13,        1, -1, -1,    1,       2, 1'b0};
    vecs[7] = '{32'h0000_0FF8, 32'd24,        0, -1, -1,    2,       3, 1'b0};

    #83;
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_done", 64'(transfer_done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_data_out", data_out, 64'd0);
    chk("rst_araddr", 64'(araddr), 64'd0);
    chk("rst_arlen", 64'(arlen), 64'd0);
    chk("const_arsize", 64'(arsize), 64'd3);
    chk("const_arburst", 64'(arburst), 64'd1);
    chk("const_arcache", 64'(arcache), 64'd3);
    chk("const_misc", 64'({arid, arlock, arprot, arqos, aruser}), 64'd0);
    #5 rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      cur_vec = i;
      run_vec(vecs[i]);
      if (i == 0) begin
        chk("log_size_ge3", 64'(log_addr.size() >= 3), 64'd1);
        if (log_addr.size() >= 3) begin
          chk("burst0_addr", 64'(log_addr[0]), 64'h1238);
          chk("burst0_len", 64'(log_len[0]), 64'd255);
          chk("burst1_addr", 64'(log_addr[1]), 64'h1A38);
          chk("burst1_len", 64'(log_len[1]), 64'd184);
          chk("burst2_addr", 64'(log_addr[2]), 64'h2000);
          chk("burst2_len", 64'(log_len[2]), 64'd255);
        end
      end
    end

    // Reset asserted in the middle of a data burst.
    cur_vec = 100;
    ar_delay = 0; err_beat = -1; early_last = -1;
    m_addr = 32'h0; m_left = 256; n_bursts = 0; n_beats = 0;
    starting_addr = 32'h0; starting_length = 32'd2048; start = 1'b1;
    cyc = 0;
    while (n_beats < 10 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_reached", 64'(n_beats >= 10), 64'd1);
    chk("mid_wr_active", 64'(wr_en), 64'd1);
    #2 rst = 1'b1; start = 1'b0;
    #1;
    chk("mid_rst_arvalid", 64'(arvalid), 64'd0);
    chk("mid_rst_rready", 64'(rready), 64'd0);
    chk("mid_rst_wr_en", 64'(wr_en), 64'd0);
    chk("mid_rst_done", 64'(transfer_done), 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rready", 64'(rready), 64'd0);
    chk("post_rst_arvalid", 64'(arvalid), 64'd0);
    cur_vec = 101;
    run_vec(vecs[7]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
